// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared FSM states, RISC-V load/store width codes, requester indices
// and the misalignment rule used by the data-memory arbiter.
package dmem_arb_pkg;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   localparam logic CORE = 1'b0;
   localparam logic DMA  = 1'b1;

   // Unknown width codes fall back to word access, matching the LW treatment of loads.
   function automatic logic misaligned(input logic we, input logic [2:0] f3, input logic [1:0] a);
      logic half, byt;
      half = we ? (f3 == SH) : (f3 == LH || f3 == LHU);
      byt  = we ? (f3 == SB) : (f3 == LB || f3 == LBU);
      return half ? a[0] : byt ? 1'b0 : |a;
   endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: one-hot grant selection between core and dma.
// DMEM_ARB_RR_EN selects round-robin with a last-grant pointer; otherwise core has fixed priority.
module dmem_arb_pick
   import dmem_arb_pkg::*;
(
`ifdef DMEM_ARB_RR_EN
   input  logic       clk,
   input  logic       reset,
`endif
   input  logic       en_i,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);

   logic win;

`ifdef DMEM_ARB_RR_EN
   logic last_q, last_d;

   always_comb begin
      win    = &req_i ? ~last_q : (req_i[0] ? CORE : DMA);
      gnt_o  = (en_i && |req_i) ? (win == DMA ? 2'b10 : 2'b01) : 2'b00;
      last_d = |gnt_o ? win : last_q;
   end

   always_ff @(posedge clk) begin
      if (reset) last_q <= DMA;
      else       last_q <= last_d;
   end
`else
   always_comb begin
      win   = req_i[0] ? CORE : DMA;
      gnt_o = (en_i && |req_i) ? (win == DMA ? 2'b10 : 2'b01) : 2'b00;
   end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester (core, dma) data-memory arbiter with IDLE/ACCESS/DONE FSM.
// Define DMEM_ARB_RR_EN for round-robin arbitration; default is fixed core priority.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [1:0]              req,
   input  logic [1:0]              we,
   input  logic [2*DM_ADDRESS-1:0] addr,
   input  logic [2*DATA_W-1:0]     wdata,
   input  logic [5:0]              funct3,
   output logic [1:0]              gnt,
   output logic [1:0]              rvalid,
   output logic                    err,
   output logic [DATA_W-1:0]       rdata,
   output logic                    mem_MemRead,
   output logic                    mem_MemWrite,
   output logic [DM_ADDRESS-1:0]   mem_a,
   output logic [DATA_W-1:0]       mem_wd,
   output logic [2:0]              mem_Funct3,
   input  logic [DATA_W-1:0]       mem_rd
);

   state_t                  state_q, state_d;
   logic                    sel_q, sel_d, we_q, we_d, mis_q, mis_d;
   logic [DM_ADDRESS-1:0]   a_q, a_d, cur_a;
   logic [DATA_W-1:0]       wd_q, wd_d, rdata_q, rdata_d, ext, cur_wd;
   logic [2:0]              f3_q, f3_d, cur_f3;
   logic                    take, cur_we, in_acc, in_done;

   dmem_arb_pick u_pick (
`ifdef DMEM_ARB_RR_EN
      .clk   (clk),
      .reset (reset),
`endif
      .en_i  (state_q == IDLE),
      .req_i (req),
      .gnt_o (gnt)
   );

   always_comb begin
      take    = |gnt;
      cur_we  = we[gnt[1]];
      cur_a   = gnt[1] ? addr[2*DM_ADDRESS-1:DM_ADDRESS] : addr[DM_ADDRESS-1:0];
      cur_wd  = gnt[1] ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
      cur_f3  = gnt[1] ? funct3[5:3] : funct3[2:0];
      in_acc  = state_q == ACCESS;
      in_done = state_q == DONE;
      sel_d   = take ? gnt[1] : sel_q;
      we_d    = take ? cur_we : we_q;
      a_d     = take ? cur_a : a_q;
      wd_d    = take ? cur_wd : wd_q;
      f3_d    = take ? cur_f3 : f3_q;
      mis_d   = take ? misaligned(cur_we, cur_f3, cur_a[1:0]) : mis_q;
      ext     = f3_q == LB  ? {{(DATA_W-8){mem_rd[7]}}, mem_rd[7:0]} :
                f3_q == LBU ? {{(DATA_W-8){1'b0}}, mem_rd[7:0]} :
                f3_q == LH  ? {{(DATA_W-16){mem_rd[15]}}, mem_rd[15:0]} :
                f3_q == LHU ? {{(DATA_W-16){1'b0}}, mem_rd[15:0]} : mem_rd;
      // Stores and misaligned accesses always return zero data.
      rdata_d = in_acc ? ((we_q || mis_q) ? '0 : ext) : rdata_q;
      state_d = state_q == IDLE ? (take ? ACCESS : IDLE) : in_acc ? DONE : IDLE;
      mem_MemRead  = in_acc && !we_q && !mis_q;
      mem_MemWrite = in_acc && we_q && !mis_q;
      mem_a        = in_acc ? a_q : '0;
      mem_wd       = in_acc ? wd_q : '0;
      mem_Funct3   = in_acc ? f3_q : '0;
      rvalid       = in_done ? (sel_q == DMA ? 2'b10 : 2'b01) : 2'b00;
      err          = in_done && mis_q;
      rdata        = in_done ? rdata_q : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         sel_q   <= 1'b0;
         we_q    <= 1'b0;
         mis_q   <= 1'b0;
         a_q     <= '0;
         wd_q    <= '0;
         f3_q    <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         we_q    <= we_d;
         mis_q   <= mis_d;
         a_q     <= a_d;
         wd_q    <= wd_d;
         f3_q    <= f3_d;
         rdata_q <= rdata_d;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized + directed scoreboard bench for dmem_arbiter.
// Honours DMEM_ARB_RR_EN so the reference arbitration matches the build.
module tb_dmem_arbiter;

   logic        clk = 0, reset = 1;
   logic [1:0]  req = 0, we = 0;
   logic [17:0] addr = 0;
   logic [63:0] wdata = 0;
   logic [5:0]  funct3 = 0;
   logic [1:0]  gnt, rvalid;
   logic        err, mem_MemRead, mem_MemWrite;
   logic [31:0] rdata, mem_wd, mem_rd;
   logic [8:0]  mem_a;
   logic [2:0]  mem_Funct3;

`ifdef DMEM_ARB_RR_EN
   localparam bit RR = 1;
`else
   localparam bit RR = 0;
`endif

   dmem_arbiter #(.DM_ADDRESS(9), .DATA_W(32)) dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .funct3(funct3), .gnt(gnt), .rvalid(rvalid), .err(err), .rdata(rdata),
      .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .mem_a(mem_a),
      .mem_wd(mem_wd), .mem_Funct3(mem_Funct3), .mem_rd(mem_rd)
   );

   logic [31:0] rom [128];
   assign mem_rd = rom[mem_a[8:2]];

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {logic [1:0] rv; logic [31:0] rd; logic e; int due;} rsp_t;
   typedef struct {logic w; logic [8:0] a; logic [31:0] d; logic [2:0] f; int due;} acc_t;
   rsp_t rsp_q[$];
   acc_t acc_q[$];
   logic [1:0] glog[$];
   int n_chk = 0, n_pass = 0, busy = 0;
   int last = 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [31:0] load_val(input logic [2:0] f, input logic [31:0] w);
      case (f)
         3'd0:    return {{24{w[7]}}, w[7:0]};
         3'd4:    return {24'b0, w[7:0]};
         3'd1:    return {{16{w[15]}}, w[15:0]};
         3'd5:    return {16'b0, w[15:0]};
         default: return w;
      endcase
   endfunction

   function automatic logic bad(input logic w, input logic [2:0] f, input logic [8:0] a);
      if (f == 3'd0 || (!w && f == 3'd4)) return 1'b0;
      if (f == 3'd1 || (!w && f == 3'd5)) return a[0];
      return a[1:0] != 2'b00;
   endfunction

   task automatic step(input logic rst, input logic [1:0] r, input logic [1:0] w,
                       input logic [17:0] a, input logic [63:0] d, input logic [5:0] f);
      logic [1:0] eg;
      int i;
      logic b, wi;
      logic [8:0] ai;
      logic [2:0] fi;
      @(posedge clk); #1;
      reset = rst; req = r; we = w; addr = a; wdata = d; funct3 = f;
      #1;
      if (rst) begin
         rsp_q.delete();
         busy = 0;
         last = 1;
         return;
      end
      i = 0;
      if (busy > 0) begin busy--; eg = 2'b00; end
      else if (r == 2'b00) eg = 2'b00;
      else begin
         i = (r == 2'b11) ? (RR ? 1 - last : 0) : (r[1] ? 1 : 0);
         eg = 2'b01 << i;
      end
      check("gnt", gnt, eg);
      if (eg != 0) begin
         wi = w[i]; ai = a[9*i +: 9]; fi = f[3*i +: 3];
         b = bad(wi, fi, ai);
         rsp_q.push_back('{eg, (wi || b) ? 32'h0 : load_val(fi, rom[ai[8:2]]), b, cyc + 2});
         if (!b) acc_q.push_back('{wi, ai, d[32*i +: 32], fi, cyc + 1});
         busy = 2;
         last = i;
         glog.push_back(eg);
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 2'b00, 2'b00, 18'h0, 64'h0, 6'h0);
   endtask

   task automatic check_zero(input string name);
      check(name, {gnt, rvalid, err, rdata, mem_MemRead, mem_MemWrite, mem_a, mem_wd, mem_Funct3}, 0);
   endtask

   always @(negedge clk) begin
      if (mem_MemRead || mem_MemWrite) begin
         check("rw_exclusive", mem_MemRead & mem_MemWrite, 0);
         if (acc_q.size() == 0) check("unexpected_mem_access", 1, 0);
         else begin
            acc_t e;
            e = acc_q.pop_front();
            check("mem_we", mem_MemWrite, e.w);
            check("mem_a", mem_a, e.a);
            check("mem_funct3", mem_Funct3, e.f);
            check("mem_cycle", cyc, e.due);
            if (e.w) check("mem_wd", mem_wd, e.d);
         end
      end
      if (rvalid != 2'b00) begin
         if (rsp_q.size() == 0) check("unexpected_rvalid", rvalid, 0);
         else begin
            rsp_t e;
            e = rsp_q.pop_front();
            check("rvalid", rvalid, e.rv);
            check("rdata", rdata, e.rd);
            check("err", err, e.e);
            check("rsp_cycle", cyc, e.due);
         end
      end
   end

   initial begin
      logic [1:0] r, w;
      logic [17:0] a;
      logic [5:0] f;
      logic [2:0] lf [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      for (int k = 0; k < 128; k++) rom[k] = $urandom;
      rom[4] = 32'hDEADBEEF;
      rom[1] = 32'h12345680;

      step(1, 2'b00, 2'b00, 18'h0, 64'h0, 6'h0);
      step(1, 2'b11, 2'b00, 18'h0, 64'h0, 6'h0);
      check_zero("reset_state");
      idle(1);
      check_zero("idle_after_reset");

      step(0, 2'b01, 2'b00, {9'h0, 9'h010}, 64'h0, {3'd0, 3'd2});
      idle(3);
      step(0, 2'b01, 2'b00, {9'h0, 9'h004}, 64'h0, {3'd0, 3'd0});
      idle(2);
      step(0, 2'b01, 2'b00, {9'h0, 9'h004}, 64'h0, {3'd0, 3'd4});
      idle(3);
      step(0, 2'b10, 2'b10, {9'h003, 9'h0}, {32'h1234, 32'h0}, {3'd1, 3'd0});
      idle(3);

      glog.delete();
      for (int k = 0; k < 12; k++) step(0, 2'b11, 2'b00, {9'h020, 9'h024}, 64'h0, {3'd2, 3'd2});
      check("arb_grant_count", glog.size(), 4);
      for (int k = 0; k < 4 && k < glog.size(); k++)
         check("arb_order", glog[k], (RR && k % 2 == 1) ? 2'b10 : 2'b01);
      idle(3);

      step(0, 2'b01, 2'b01, {9'h0, 9'h008}, {32'h0, 32'hCAFEF00D}, {3'd0, 3'd2});
      step(1, 2'b00, 2'b00, 18'h0, 64'h0, 6'h0);
      step(0, 2'b00, 2'b00, 18'h0, 64'h0, 6'h0);
      check_zero("after_reset_in_access");
      idle(3);

      for (int k = 0; k < 400; k++) begin
         r = 2'($urandom);
         for (int j = 0; j < 2; j++) begin
            w[j] = 1'($urandom);
            f[3*j +: 3] = w[j] ? 3'($urandom_range(0, 2)) : lf[$urandom_range(0, 4)];
            a[9*j +: 9] = 9'($urandom);
            if ($urandom % 2) a[9*j +: 2] = 2'b00;
         end
         step(0, r, w, a, {$urandom, $urandom}, f);
      end

      for (int k = 0; k < 10 && (rsp_q.size() != 0 || acc_q.size() != 0); k++) idle(1);
      check("rsp_drained", rsp_q.size(), 0);
      check("acc_drained", acc_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
